// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// DMEM_BYTE_STROBE_EN (see dmem_responder) selects per-lane stores.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_BYTES = 8;
  localparam int OFFSET_W   = 3;

  function automatic logic is_aligned(input logic [OFFSET_W-1:0] low_bits);
    return (low_bits == '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage with byte-lane write and registered read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wr_data,
  input  logic [7:0]    wr_strb,
  output logic [63:0]   rd_data
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wr_strb[i]) begin
          mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with programmable wait states.
// Define DMEM_BYTE_STROBE_EN to honour req_wstrb; otherwise stores write all lanes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_t state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [63:0]       wdata_reg;
  logic [7:0]        wstrb_reg;
  logic              rsp_load_reg;
  logic              rsp_err_reg;

  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [63:0]       cur_wdata;
  logic [7:0]        cur_wstrb;
  logic [7:0]        wstrb_eff;
  logic              addr_err;
  logic              enter_resp;
  logic [63:0]       arr_rdata;

  // With zero wait states the commit happens on the accept edge, so the
  // live request is used instead of the (not yet loaded) latch.
  assign cur_write = (state_reg == IDLE) ? req_write : write_reg;
  assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign cur_wstrb = (state_reg == IDLE) ? req_wstrb : wstrb_reg;

`ifdef DMEM_BYTE_STROBE_EN
  assign wstrb_eff = cur_wstrb;
`else
  assign wstrb_eff = cur_wstrb | 8'hFF;
`endif

  assign addr_err = !is_aligned(cur_addr[OFFSET_W-1:0]) ||
                    ((cur_addr >> OFFSET_W) >= ADDR_W'(DEPTH));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          cnt_next   = CNT_LOAD;
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = RESP;
        else cnt_next = cnt_reg - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_reg != RESP) && (state_next == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else if (state_reg == IDLE && req_valid) begin
      write_reg <= req_write;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      wstrb_reg <= req_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_load_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
    end else if (enter_resp) begin
      rsp_load_reg <= !cur_write && !addr_err;
      rsp_err_reg  <= addr_err;
    end else if (state_reg == RESP && rsp_ready) begin
      rsp_load_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk    (clk),
    .wr_en  (enter_resp && cur_write && !addr_err),
    .rd_en  (enter_resp && !cur_write && !addr_err),
    .addr   (cur_addr[OFFSET_W +: AW]),
    .wr_data(cur_wdata),
    .wr_strb(wstrb_eff),
    .rd_data(arr_rdata)
  );

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_load_reg ? arr_rdata : 64'd0;
  assign rsp_err   = rsp_err_reg;

endmodule
